regfile_wb_arbiter: RTL and testbench

Write-back scheduler for the 32×32 `Registers` file. It shares the file's single write port (`RegWrite`/`WriteAddr`/`WriteData`) between the ALU result path and the load-return path using round-robin valid/ready arbitration. It also keeps a scoreboard of registers with outstanding loads, so decode can stall on read-after-write hazards. It sits between execute/memory and the register file; its outputs drive the file's write port directly.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/wb_scoreboard.sv | 63 ++++++
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file constants and write-back request type
// Purpose: widths and constants shared by the write-back arbiter, its scoreboard
//          and its bus interface.
// Ports:   none (package).
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int REG_N  = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   // One write-back request as it travels toward the register file port.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request/ready bus and register file write port
// Purpose: bundles the ALU and load-return valid/ready requests with the
//          registered write port that drives the register file.
// Ports:   AluValid/AluRd/AluData/AluReady, LdValid/LdRd/LdData/LdReady,
//          RegWrite/WriteAddr/WriteData.
//          master = execute/memory side, slave = write-back arbiter.
interface regfile_wb_arbiter_if;
   import riscv_pkg::*;

   logic              AluValid;
   logic [REG_AW-1:0] AluRd;
   logic [XLEN-1:0]   AluData;
   logic              AluReady;
   logic              LdValid;
   logic [REG_AW-1:0] LdRd;
   logic [XLEN-1:0]   LdData;
   logic              LdReady;
   logic              RegWrite;
   logic [REG_AW-1:0] WriteAddr;
   logic [XLEN-1:0]   WriteData;

   modport master (
      output AluValid, AluRd, AluData, LdValid, LdRd, LdData,
      input  AluReady, LdReady, RegWrite, WriteAddr, WriteData
   );

   modport slave (
      input  AluValid, AluRd, AluData, LdValid, LdRd, LdData,
      output AluReady, LdReady, RegWrite, WriteAddr, WriteData
   );

endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - busy table for registers with outstanding loads
// Purpose: one busy bit per register, set on load issue and cleared when the
//          load write-back commits; flags double issue and produces the busy
//          part of the decode stall.
// Ports:   clk, reset            - clock, synchronous active-high reset
//          set_en/set_addr       - load issued to set_addr
//          clr_en/clr_addr       - load write-back committing to clr_addr
//          rd_addr1/rd_addr2     - decode source registers
//          busy                  - full busy vector
//          busy_stall            - a source register is busy
//          err_double            - sticky: issue to an already-busy register
module wb_scoreboard
   import riscv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_addr,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_addr,
   input  logic [REG_AW-1:0] rd_addr1,
   input  logic [REG_AW-1:0] rd_addr2,
   output logic [REG_N-1:0]  busy,
   output logic              busy_stall,
   output logic              err_double
);

   logic [REG_N-1:0] busy_q, busy_d;
   logic             err_double_q, err_double_d;
   logic             set_live;
   logic             clr_same;

   always_comb begin
      set_live = set_en & (set_addr != REG_ZERO);
      clr_same = clr_en & (clr_addr == set_addr);

      // Clear first so a same-cycle set on the same register wins.
      busy_d = busy_q;
      if (clr_en)
         busy_d[clr_addr] = 1'b0;
      if (set_live)
         busy_d[set_addr] = 1'b1;
      busy_d[0] = 1'b0;

      // Re-issuing to a register whose load commits this very cycle is legal.
      err_double_d = err_double_q | (set_live & busy_q[set_addr] & ~clr_same);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q       <= '0;
         err_double_q <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         err_double_q <= err_double_d;
      end
   end

   assign busy       = busy_q;
   assign busy_stall = busy_q[rd_addr1] | busy_q[rd_addr2];
   assign err_double = err_double_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back scheduler for the register file
// Purpose: shares the single register-file write port between the ALU and
//          load-return paths, registers the winning write, and reports
//          read-after-write hazards to decode.
// Ports:   clk, reset              - clock, synchronous active-high reset
//          bus (slave)             - ALU/load requests and register write port
//          LdIssue/LdIssueRd       - load issued, destination marked busy
//          ReadAddr1/ReadAddr2     - decode source registers
//          Stall                   - decode must hold
//          ErrDouble/ErrOrphan     - sticky protocol error flags
module regfile_wb_arbiter
   import riscv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   regfile_wb_arbiter_if.slave bus,
   input  logic              LdIssue,
   input  logic [REG_AW-1:0] LdIssueRd,
   input  logic [REG_AW-1:0] ReadAddr1,
   input  logic [REG_AW-1:0] ReadAddr2,
   output logic              Stall,
   output logic              ErrDouble,
   output logic              ErrOrphan
);

   // prio_q: 0 favours the load path, 1 favours the ALU path.
   logic              prio_q, prio_d;
   logic              reg_write_q, reg_write_d;
   logic [REG_AW-1:0] write_addr_q, write_addr_d;
   logic [XLEN-1:0]   write_data_q, write_data_d;
   logic              wb_is_ld_q, wb_is_ld_d;
   logic              err_orphan_q, err_orphan_d;

   logic              grant_ld, grant_alu;
   wb_req_t           sel;
   logic [REG_N-1:0]  busy;
   logic              busy_stall;
   logic              hazard_stall;

   always_comb begin
      // Grants are suppressed in reset so nothing accepted then reaches the file.
      grant_ld  = bus.LdValid  & (~bus.AluValid | ~prio_q) & ~reset;
      grant_alu = bus.AluValid & (~bus.LdValid  |  prio_q) & ~reset;

      sel.rd   = grant_ld ? bus.LdRd   : bus.AluRd;
      sel.data = grant_ld ? bus.LdData : bus.AluData;

      // After a contested grant, point at the side that lost.
      prio_d = prio_q;
      if (bus.AluValid & bus.LdValid)
         prio_d = grant_ld;

      reg_write_d  = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      wb_is_ld_d   = 1'b0;
      if (grant_ld | grant_alu) begin
         reg_write_d  = (sel.rd != REG_ZERO);
         write_addr_d = sel.rd;
         write_data_d = sel.data;
         wb_is_ld_d   = grant_ld;
      end

      err_orphan_d = err_orphan_q
                   | (grant_ld & (bus.LdRd != REG_ZERO) & ~busy[bus.LdRd]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q       <= 1'b0;
         reg_write_q  <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         wb_is_ld_q   <= 1'b0;
         err_orphan_q <= 1'b0;
      end else begin
         prio_q       <= prio_d;
         reg_write_q  <= reg_write_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         wb_is_ld_q   <= wb_is_ld_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   // Busy bit drops on the edge that writes the file, i.e. when data becomes readable.
   wb_scoreboard u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .set_en     (LdIssue),
      .set_addr   (LdIssueRd),
      .clr_en     (reg_write_q & wb_is_ld_q),
      .clr_addr   (write_addr_q),
      .rd_addr1   (ReadAddr1),
      .rd_addr2   (ReadAddr2),
      .busy       (busy),
      .busy_stall (busy_stall),
      .err_double (ErrDouble)
   );

   // The file has no write-through, so a write in flight also blocks its readers.
   assign hazard_stall = reg_write_q & (write_addr_q != REG_ZERO)
                       & ((write_addr_q == ReadAddr1) | (write_addr_q == ReadAddr2));

   assign Stall        = busy_stall | hazard_stall;
   assign ErrOrphan    = err_orphan_q;
   assign bus.AluReady = grant_alu;
   assign bus.LdReady  = grant_ld;
   assign bus.RegWrite = reg_write_q;
   assign bus.WriteAddr = write_addr_q;
   assign bus.WriteData = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        LdIssue;
   logic [4:0]  LdIssueRd;
   logic [4:0]  ReadAddr1;
   logic [4:0]  ReadAddr2;
   logic        Stall;
   logic        ErrDouble;
   logic        ErrOrphan;

   int total = 0;
   int bad   = 0;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .LdIssue   (LdIssue),
      .LdIssueRd (LdIssueRd),
      .ReadAddr1 (ReadAddr1),
      .ReadAddr2 (ReadAddr2),
      .Stall     (Stall),
      .ErrDouble (ErrDouble),
      .ErrOrphan (ErrOrphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model fed by the write port.
   logic [31:0] tb_regs [32];
   logic        seen8 = 1'b0;
   always @(posedge clk) begin
      if (bus.RegWrite && bus.WriteAddr != 5'd0) begin
         tb_regs[bus.WriteAddr] <= bus.WriteData;
         if (bus.WriteAddr == 5'd8)
            seen8 <= 1'b1;
      end
   end

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adata;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      logic        iss;
      logic [4:0]  issrd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        e_ardy;
      logic        e_lrdy;
      logic        e_stall;
      logic        e_rw;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_errd;
      logic        e_erro;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.AluValid = 1'b0; bus.AluRd = '0; bus.AluData = '0;
      bus.LdValid  = 1'b0; bus.LdRd  = '0; bus.LdData  = '0;
      LdIssue = 1'b0; LdIssueRd = '0; ReadAddr1 = '0; ReadAddr2 = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive_idle();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int i);
      bus.AluValid = v.av; bus.AluRd = v.ard; bus.AluData = v.adata;
      bus.LdValid  = v.lv; bus.LdRd  = v.lrd; bus.LdData  = v.ldata;
      LdIssue = v.iss; LdIssueRd = v.issrd; ReadAddr1 = v.ra1; ReadAddr2 = v.ra2;
      #1;
      chk($sformatf("v%0d_alu_ready", i), {31'd0, bus.AluReady}, {31'd0, v.e_ardy});
      chk($sformatf("v%0d_ld_ready", i),  {31'd0, bus.LdReady},  {31'd0, v.e_lrdy});
      chk($sformatf("v%0d_stall", i),     {31'd0, Stall},        {31'd0, v.e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_reg_write", i), {31'd0, bus.RegWrite}, {31'd0, v.e_rw});
      chk($sformatf("v%0d_write_addr", i), {27'd0, bus.WriteAddr}, {27'd0, v.e_wa});
      chk($sformatf("v%0d_write_data", i), bus.WriteData, v.e_wd);
      chk($sformatf("v%0d_err_double", i), {31'd0, ErrDouble}, {31'd0, v.e_errd});
      chk($sformatf("v%0d_err_orphan", i), {31'd0, ErrOrphan}, {31'd0, v.e_erro});
      @(negedge clk);
   endtask

   logic [4:0]  c_wa   [4];
   logic        c_lrdy [4];

   initial begin
      //          av ard adata        lv lrd ldata        iss rd  ra1 ra2 ardy lrdy stl rw  wa   wd           ed eo
      vecs[0]  = '{1, 5, 32'hAAAAAAAA, 0, 0, 32'h0,        0,  0,  0,  0,  1,   0,  0,  1,  5,  32'hAAAAAAAA, 0, 0};
      vecs[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  5,  0,  0,   0,  1,  0,  5,  32'hAAAAAAAA, 0, 0};
      vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  5,  0,  0,   0,  0,  0,  5,  32'hAAAAAAAA, 0, 0};
      vecs[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 10,  0,  0,  0,   0,  0,  0,  5,  32'hAAAAAAAA, 0, 0};
      vecs[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 10,  0,  0,   0,  1,  0,  5,  32'hAAAAAAAA, 0, 0};
      vecs[5]  = '{0, 0, 32'h0,        1,10, 32'h12345678, 0,  0, 10,  0,  0,   1,  1,  1, 10,  32'h12345678, 0, 0};
      vecs[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 10,  0,  0,   0,  1,  0, 10,  32'h12345678, 0, 0};
      vecs[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 10,  0,  0,   0,  0,  0, 10,  32'h12345678, 0, 0};
      vecs[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  0, 11,  0,   0,  0,  0, 10,  32'h12345678, 0, 0};
      vecs[9]  = '{1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0,  0,  0,  0,  1,   0,  0,  0,  0,  32'hDEADBEEF, 0, 0};
      vecs[10] = '{0, 0, 32'h0,        0, 0, 32'h0,        1,  0,  0,  0,  0,   0,  0,  0,  0,  32'hDEADBEEF, 0, 0};
      vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  0,  0,  0,   0,  0,  0,  0,  32'hDEADBEEF, 0, 0};
      vecs[12] = '{0, 0, 32'h0,        0, 0, 32'h0,        1,  6,  0,  0,  0,   0,  0,  0,  0,  32'hDEADBEEF, 0, 0};
      vecs[13] = '{0, 0, 32'h0,        1, 6, 32'h00000066, 0,  0,  0,  0,  0,   1,  0,  1,  6,  32'h00000066, 0, 0};
      vecs[14] = '{0, 0, 32'h0,        0, 0, 32'h0,        1,  6,  0,  0,  0,   0,  0,  0,  6,  32'h00000066, 0, 0};
      vecs[15] = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  6,  0,  0,   0,  1,  0,  6,  32'h00000066, 0, 0};
      vecs[16] = '{0, 0, 32'h0,        0, 0, 32'h0,        1,  4,  0,  0,  0,   0,  0,  0,  6,  32'h00000066, 0, 0};
      vecs[17] = '{0, 0, 32'h0,        0, 0, 32'h0,        1,  4,  0,  0,  0,   0,  0,  0,  6,  32'h00000066, 1, 0};
      vecs[18] = '{0, 0, 32'h0,        1, 9, 32'h00000099, 0,  0,  0,  0,  0,   1,  0,  1,  9,  32'h00000099, 1, 1};
      vecs[19] = '{0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  4,  0,  0,   0,  1,  0,  9,  32'h00000099, 1, 1};

      drive_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_reg_write",  {31'd0, bus.RegWrite}, 32'd0);
      chk("rst_write_addr", {27'd0, bus.WriteAddr}, 32'd0);
      chk("rst_write_data", bus.WriteData, 32'd0);
      chk("rst_err_double", {31'd0, ErrDouble}, 32'd0);
      chk("rst_err_orphan", {31'd0, ErrOrphan}, 32'd0);
      chk("rst_alu_ready",  {31'd0, bus.AluReady}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 20; i++)
         apply(vecs[i], i);

      chk("file_x5",  tb_regs[5],  32'hAAAAAAAA);
      chk("file_x10", tb_regs[10], 32'h12345678);
      chk("file_x6",  tb_regs[6],  32'h00000066);
      chk("file_x9",  tb_regs[9],  32'h00000099);

      // Contention: load favoured first after reset, then alternating.
      do_reset();
      drive_idle();
      LdIssue = 1'b1; LdIssueRd = 5'd7;
      @(negedge clk);
      LdIssue = 1'b0;
      c_wa[0] = 5'd7; c_wa[1] = 5'd3; c_wa[2] = 5'd7; c_wa[3] = 5'd3;
      c_lrdy[0] = 1'b1; c_lrdy[1] = 1'b0; c_lrdy[2] = 1'b1; c_lrdy[3] = 1'b0;
      bus.AluValid = 1'b1; bus.AluRd = 5'd3; bus.AluData = 32'hA3A3A3A3;
      bus.LdValid  = 1'b1; bus.LdRd  = 5'd7; bus.LdData  = 32'h17171717;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("cont%0d_ld_ready", i),  {31'd0, bus.LdReady},  {31'd0, c_lrdy[i]});
         chk($sformatf("cont%0d_alu_ready", i), {31'd0, bus.AluReady}, {31'd0, ~c_lrdy[i]});
         @(posedge clk);
         #1;
         chk($sformatf("cont%0d_write_addr", i), {27'd0, bus.WriteAddr}, {27'd0, c_wa[i]});
         chk($sformatf("cont%0d_write_data", i), bus.WriteData,
             c_lrdy[i] ? 32'h17171717 : 32'hA3A3A3A3);
         chk($sformatf("cont%0d_reg_write", i), {31'd0, bus.RegWrite}, 32'd1);
         @(negedge clk);
      end
      drive_idle();
      @(posedge clk);
      #1;
      // Second load to x7 arrives after the first one already cleared the busy bit.
      chk("cont_err_orphan", {31'd0, ErrOrphan}, 32'd1);
      @(negedge clk);

      // Reset while an ALU request is presented.
      LdIssue = 1'b1; LdIssueRd = 5'd12;
      @(negedge clk);
      LdIssue = 1'b0;
      ReadAddr1 = 5'd12;
      #1;
      chk("pre_rst_stall", {31'd0, Stall}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      bus.AluValid = 1'b1; bus.AluRd = 5'd8; bus.AluData = 32'h88888888;
      #1;
      chk("midrst_alu_ready", {31'd0, bus.AluReady}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.AluValid = 1'b0;
      chk("midrst_reg_write",  {31'd0, bus.RegWrite}, 32'd0);
      chk("midrst_err_orphan", {31'd0, ErrOrphan}, 32'd0);
      chk("midrst_err_double", {31'd0, ErrDouble}, 32'd0);
      chk("midrst_stall_busy", {31'd0, Stall}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_no_x8_write", {31'd0, seen8}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
